fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset; must be word-aligned.
REQ-002 SHALL have parameter IMEM_WORDS, default 1024, meaning number of valid instruction-memory words; the legal PC range is 0 to 4*IMEM_WORDS-4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port fetch_en  input  1  permits capture of new instructions.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  16  redirect target byte address.
REQ-008 SHALL have port imem_addr  output  16  byte address to instruction memory, equal to the PC register (combinational from the register).
REQ-009 SHALL have port imem_rd  input  32  instruction word returned combinationally by the memory for imem_addr.
REQ-010 SHALL have port instr_out  output  32  registered instruction to decode.
REQ-011 SHALL have port instr_pc  output  16  PC of instr_out.
REQ-012 SHALL have port instr_valid  output  1  instr_out holds a valid instruction.
REQ-013 SHALL have port dec_ready  input  1  decoder accepts instr_out this cycle.
REQ-014 SHALL have port fetch_fault  output  1  PC left the legal range; fetch is halted.
REQ-015 SHALL have port retire_cnt  output  16  count of instructions accepted by decode.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FAULT.
REQ-017 SHALL transition IDLE->RUN when fetch_en=1 and RUN->IDLE when fetch_en=0; a valid instr_out SHALL still drain in IDLE.
REQ-018 SHALL perform a capture in RUN when fetch_en=1 and redirect_valid=0 and (instr_valid=0 or dec_ready=1) and PC is in range; a capture SHALL load instr_out<=imem_rd, instr_pc<=PC and instr_valid<=1, and set PC<=PC+4.
REQ-019 SHALL have a latency of one cycle: the word at imem_addr in cycle N appears on instr_out in cycle N+1.
REQ-020 SHALL hold instr_out, instr_pc, instr_valid and PC stable while instr_valid=1 and dec_ready=0.
REQ-021 SHALL clear instr_valid on a handshake (instr_valid=1 and dec_ready=1) with no capture in the same cycle.
REQ-022 SHALL give redirect_valid priority over capture in any state: PC<=redirect_pc with bits [1:0] forced to 0, and instr_valid<=0 (flush) in the same edge; the state is otherwise unchanged except per REQ-024.
REQ-023 SHALL, when a capture would occur with PC >= 4*IMEM_WORDS, suppress the capture, enter FAULT and set fetch_fault=1; a pending instr_out SHALL still drain.
REQ-024 SHALL leave FAULT to RUN with fetch_fault=0 on a redirect to an in-range target; an out-of-range redirect SHALL keep FAULT.
REQ-025 SHALL compute PC+4 modulo 2^16 (16'hFFFC wraps to 16'h0000); with the default IMEM_WORDS a fault triggers first.
REQ-026 SHALL increment retire_cnt on each handshake, saturating at 16'hFFFF; a handshake that coincides with a redirect SHALL still count.

Reset
REQ-027 SHALL on rst=1 set PC=RESET_PC, state IDLE, instr_out=0, instr_pc=0, instr_valid=0, fetch_fault=0 and retire_cnt=0; rst SHALL override all other inputs.
REQ-028 SHALL discard any in-flight instruction when reset is asserted mid-operation; the first capture after release SHALL be from RESET_PC.

Structure
REQ-029 SHALL take PC_W=16, INSTR_W=32, the fetch-state enum and the opcode constants (R-type 7'b0110011, I-type 7'b0010011) from the shared package cpu_pkg.
REQ-030 SHALL place the PC register, its next-PC mux (hold / +4 / redirect / reset) and range check in the sub-module program_counter; fetch_unit SHALL own the FSM, output buffer and counter.

Verification
REQ-031 SHALL cover reset then fetch_en=1 with dec_ready=1 held: instr_pc sequence 0x0000, 0x0004, 0x0008, ... one per cycle; instr_out at 0x0000 = 32'h00110033; retire_cnt increments by 1 per cycle.
REQ-032 SHALL cover stall: dec_ready=0 for 3 cycles with instr_pc=0x0008: outputs and imem_addr=0x000C are frozen; on release 0x0008 retires and 0x000C follows next cycle.
REQ-033 SHALL cover redirect: redirect_valid=1 with redirect_pc=0x0016 while instr_valid=1: next cycle instr_valid=0 and imem_addr=0x0014; the following cycle instr_pc=0x0014 and instr_out=32'h00000200.
REQ-034 SHALL cover range fault: redirect to 0x0FFC and run: 0x0FFC retires, then fetch_fault=1 and instr_valid stays 0; redirect to 0x0000 clears the fault and resumes.
REQ-035 SHALL cover reset mid-stream: rst=1 for one cycle while instr_valid=1 and retire_cnt=5: all outputs return to their reset values and fetch resumes at 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM states and opcode constants for the CPU front end.
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_e;

    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with hold / +4 / redirect / reset next-PC mux and
// legality checks for both the current PC and a pending redirect target.
module program_counter
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
    parameter int              IMEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic            pc_in_range_o,
    output logic            target_in_range_o
);
    localparam int unsigned LIMIT = 4 * IMEM_WORDS;

    logic [PC_W-1:0] pc_q, pc_d;

    // Redirect beats advance; the +4 wraps modulo 2^16.
    always_comb begin
        pc_d = redirect_i ? align_word(redirect_pc_i) : advance_i ? pc_q + 16'd4 : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc_o              = pc_q;
    assign pc_in_range_o     = 32'(pc_q) < LIMIT;
    assign target_in_range_o = 32'(align_word(redirect_pc_i)) < LIMIT;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with IDLE/RUN/FAULT control, a one-entry output
// buffer to decode, redirect flush and a saturating retire counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
    parameter int              IMEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               dec_ready,
    output logic               fetch_fault,
    output logic [PC_W-1:0]    retire_cnt
);
    fetch_state_e       state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    ipc_q, cnt_q, pc;
    logic               valid_q, fault_q, pc_ok, tgt_ok;
    logic               handshake, want, capture;

    assign handshake = valid_q && dec_ready;
    // A capture is wanted whenever the buffer can take a word; it only happens if PC is legal.
    assign want      = state_q == RUN && fetch_en && !redirect_valid && (!valid_q || dec_ready);
    assign capture   = want && pc_ok;

    program_counter #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS)
    ) u_pc (
        .clk              (clk),
        .rst              (rst),
        .advance_i        (capture),
        .redirect_i       (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_o             (pc),
        .pc_in_range_o    (pc_ok),
        .target_in_range_o(tgt_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (handshake && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            if (redirect_valid) begin
                valid_q <= 1'b0;
                if (state_q == FAULT && tgt_ok) begin
                    state_q <= RUN;
                    fault_q <= 1'b0;
                end
            end else if (capture) begin
                instr_q <= imem_rd;
                ipc_q   <= pc;
                valid_q <= 1'b1;
            end else begin
                if (handshake) valid_q <= 1'b0;
                case (state_q)
                    IDLE: if (fetch_en) state_q <= RUN;
                    RUN: begin
                        if (!fetch_en) state_q <= IDLE;
                        else if (want) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_addr   = pc;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign retire_cnt  = cnt_q;
endmodule
